// File: rtl/fft8_pkg.sv
// Shared constants, input FSM states and bus slicing helper for the 8-point FFT
// frame controller.
package fft8_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        COMPUTE
    } in_state_e;

    // Word k of a flat N*W bus; word k sits on bits [W*k+W-1:W*k].
    function automatic logic [W-1:0] word_slice(input logic [N*W-1:0]   bus,
                                                input logic [IDX_W-1:0] k);
        return bus[k*W +: W];
    endfunction

endpackage

// File: rtl/fft8_out_buf.sv
// Output side: captures the 8 re/im result words in one shot and streams them
// as bins 0..7 over a valid/ready handshake.
module fft8_out_buf
    import fft8_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             capture_i,
    input  logic [N*W-1:0]   fft_re,
    input  logic [N*W-1:0]   fft_im,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [W-1:0]     m_re,
    output logic [W-1:0]     m_im,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_last,
    output logic             full_o,
    output logic             release_o
);

    logic [N-1:0][W-1:0] re_q;
    logic [N-1:0][W-1:0] im_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic                full_q;
    logic                fire;

    assign fire      = full_q && m_ready;
    assign m_valid   = full_q;
    assign m_re      = re_q[rd_idx_q];
    assign m_im      = im_q[rd_idx_q];
    assign m_idx     = rd_idx_q;
    assign m_last    = full_q && (rd_idx_q == IDX_W'(N-1));
    assign full_o    = full_q;
    assign release_o = fire && m_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q     <= '0;
            im_q     <= '0;
            rd_idx_q <= '0;
            full_q   <= 1'b0;
        end else if (abort) begin
            re_q     <= '0;
            im_q     <= '0;
            rd_idx_q <= '0;
            full_q   <= 1'b0;
        end else if (capture_i) begin
            // The FSM only captures into an empty buffer, so no drain is lost here.
            for (int k = 0; k < N; k++) begin
                re_q[k] <= word_slice(fft_re, IDX_W'(k));
                im_q[k] <= word_slice(fft_im, IDX_W'(k));
            end
            rd_idx_q <= '0;
            full_q   <= 1'b1;
        end else if (fire) begin
            rd_idx_q <= rd_idx_q + 1'b1;
            if (rd_idx_q == IDX_W'(N-1)) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around a combinational 8-point FFT: fills an input buffer,
// holds it on the datapath for SETTLE extra cycles, captures and drains results.
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int W      = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic [8*W-1:0]   fft_x,
    input  logic [8*W-1:0]   fft_re,
    input  logic [8*W-1:0]   fft_im,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_re,
    output logic [W-1:0]     m_im,
    output logic [2:0]       m_idx,
    output logic             m_last,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    in_state_e           state_q;
    logic                s_ready_q;
    logic [IDX_W-1:0]    wr_idx_q;
    logic [3:0]          cnt_q;
    logic [N-1:0][W-1:0] in_buf_q;
    logic [15:0]         frame_cnt_q;

    logic accept;
    logic capture;
    logic out_full;
    logic out_release;
    logic can_capture;

    assign accept      = s_valid && s_ready_q;
    // An output buffer releasing this cycle counts as empty for the next capture.
    assign can_capture = !out_full || out_release;
    assign capture     = (state_q == COMPUTE) && (cnt_q == 4'(SETTLE));

    assign s_ready   = s_ready_q;
    assign fft_x     = in_buf_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = ((state_q != FILL) && (state_q != IDLE)) || out_full || (wr_idx_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            wr_idx_q    <= '0;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            frame_cnt_q <= '0;
        end else if (abort) begin
            state_q   <= FILL;
            s_ready_q <= 1'b1;
            wr_idx_q  <= '0;
            cnt_q     <= '0;
            in_buf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= FILL;
                    s_ready_q <= 1'b1;
                end
                FILL: begin
                    if (accept) begin
                        in_buf_q[wr_idx_q] <= s_data;
                        wr_idx_q           <= wr_idx_q + 1'b1;
                        if (wr_idx_q == IDX_W'(N-1)) begin
                            s_ready_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= can_capture ? COMPUTE : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (can_capture) begin
                        state_q <= COMPUTE;
                        cnt_q   <= '0;
                    end
                end
                COMPUTE: begin
                    if (capture) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= FILL;
                        s_ready_q   <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fft8_out_buf #(
        .W(W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .capture_i (capture),
        .fft_re    (fft_re),
        .fft_im    (fft_im),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .full_o    (out_full),
        .release_o (out_release)
    );

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl: directed scenarios plus a random phase, with a
// queue-based frame model of the stub datapath (re = x_k + k, im = ~x_k).
module tb_fft8_frame_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, abort, s_valid, m_ready;
    logic [W-1:0] s_data;

    logic           s_ready1, m_valid1, m_last1, busy1;
    logic [8*W-1:0] x1, re1, im1;
    logic [W-1:0]   m_re1, m_im1;
    logic [2:0]     m_idx1;
    logic [15:0]    fcnt1;

    logic           s_ready3, m_valid3, m_last3, busy3;
    logic [8*W-1:0] x3, re3, im3;
    logic [W-1:0]   m_re3, m_im3;
    logic [2:0]     m_idx3;
    logic [15:0]    fcnt3;

    for (genvar k = 0; k < 8; k++) begin : g_stub
        assign re1[k*W +: W] = x1[k*W +: W] + 16'(k);
        assign im1[k*W +: W] = ~x1[k*W +: W];
        assign re3[k*W +: W] = x3[k*W +: W] + 16'(k);
        assign im3[k*W +: W] = ~x3[k*W +: W];
    end

    fft8_frame_ctrl #(.W(W), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .fft_x(x1), .fft_re(re1), .fft_im(im1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_re(m_re1), .m_im(m_im1),
        .m_idx(m_idx1), .m_last(m_last1), .busy(busy1), .frame_cnt(fcnt1)
    );

    fft8_frame_ctrl #(.W(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
        .fft_x(x3), .fft_re(re3), .fft_im(im3),
        .m_valid(m_valid3), .m_ready(m_ready), .m_re(m_re3), .m_im(m_im3),
        .m_idx(m_idx3), .m_last(m_last3), .busy(busy3), .frame_cnt(fcnt3)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: samples accumulate into frames; a full frame yields 8 bins in order.
    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
    } bin_t;

    logic [W-1:0] part_q[$];
    bin_t         exp_q[$];

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            part_q.delete();
            exp_q.delete();
        end else begin
            if (m_valid1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_bin", m_valid1, 0);
                end else begin
                    chk("bin_re",   m_re1,   exp_q[0].re);
                    chk("bin_im",   m_im1,   exp_q[0].im);
                    chk("bin_idx",  m_idx1,  exp_q[0].idx);
                    chk("bin_last", m_last1, exp_q[0].idx == 3'd7);
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
            if (s_valid && s_ready1) begin
                part_q.push_back(s_data);
                if (part_q.size() == 8) begin
                    for (int k = 0; k < 8; k++)
                        exp_q.push_back('{re: part_q[k] + 16'(k), im: ~part_q[k], idx: 3'(k)});
                    part_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves s_valid high so frames can stream back-to-back.
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        tick();
    endtask

    task automatic send_frame(input logic [W-1:0] base);
        for (int i = 0; i < 8; i++) send(base + 16'(i));
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_valid1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || m_valid1) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < 400, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;

        rst_n = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) tick();
        chk("rst_s_ready", s_ready1, 0);
        chk("rst_busy",    busy1,    0);
        chk("rst_m_valid", m_valid1, 0);
        chk("rst_fcnt",    fcnt1,    0);
        chk("rst_fft_x",   |x1,      0);
        rst_n = 1'b1;
        chk("s_ready_cyc1", s_ready1, 0);
        tick();
        chk("s_ready_cyc2", s_ready1, 1);
        chk("busy_fill",    busy1,    0);

        // Basic frame
        m_ready = 1'b1;
        send_frame(16'h0010);
        wait_valid(lat);
        chk("lat_basic", lat, 2);
        chk("b0_re", m_re1, 16'h0010);
        chk("b0_im", m_im1, 16'hFFEF);
        wait_idle();
        chk("fcnt_basic", fcnt1, 1);

        // Backpressure at idx 3
        m_ready = 1'b0;
        send_frame(16'h0010);
        wait_valid(lat);
        chk("lat_bp", lat, 2);
        m_ready = 1'b1;
        n = 0;
        while (m_idx1 != 3'd3 && n < 20) begin tick(); n++; end
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_re",  m_re1,  16'h0016);
            chk("bp_idx", m_idx1, 3);
        end
        m_ready = 1'b1;
        tick();
        chk("bp_resume_idx", m_idx1, 4);
        wait_idle();
        chk("fcnt_bp", fcnt1, 2);

        // Overlap: second frame waits while first stalls at idx 5
        m_ready = 1'b0;
        send_frame(16'h0040);
        wait_valid(lat);
        m_ready = 1'b1;
        n = 0;
        while (m_idx1 != 3'd5 && n < 20) begin tick(); n++; end
        m_ready = 1'b0;
        send_frame(16'h0080);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_s_ready", s_ready1, 0);
            chk("hold_busy",    busy1,    1);
            chk("hold_idx",     m_idx1,   5);
        end
        m_ready = 1'b1;
        n = 0;
        while (!m_last1 && n < 20) begin tick(); n++; end
        tick();
        wait_valid(lat);
        chk("lat_hold", lat, 2);
        chk("hold_s_ready_after", s_ready1, 1);
        chk("hold_b0_re", m_re1, 16'h0080);
        wait_idle();
        chk("fcnt_overlap", fcnt1, 4);

        // Abort after 5 samples
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(16'h0055 + 16'(i));
        s_valid = 1'b0;
        chk("pre_abort_busy", busy1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",    busy1,    0);
        chk("abort_s_ready", s_ready1, 1);
        chk("abort_fcnt",    fcnt1,    4);
        chk("abort_fft_x",   |x1,      0);
        send_frame(16'h00A0);
        wait_valid(lat);
        chk("lat_abort", lat, 2);
        chk("abort_b0_re", m_re1, 16'h00A0);
        wait_idle();
        chk("fcnt_abort", fcnt1, 5);

        // Random traffic with random gaps and backpressure
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    for (int i = 0; i < 8; i++) begin
                        if ($urandom_range(3) == 0) begin
                            s_valid = 1'b0;
                            repeat ($urandom_range(3, 1)) tick();
                        end
                        send(16'($urandom));
                    end
                    s_valid = 1'b0;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_ready = ($urandom_range(2) != 0);
                    tick();
                end
            end
        join
        m_ready = 1'b1;
        wait_idle();
        chk("fcnt_rand",    fcnt1,         11);
        chk("rand_drained", exp_q.size(), 0);

        // SETTLE=3 latency and async reset mid-drain
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("r2_fcnt3", fcnt3, 0);
        m_ready = 1'b0;
        send_frame(16'h0030);
        n = 0;
        while (!m_valid3 && n < 100) begin tick(); n++; end
        chk("lat_settle3", n, 4);
        chk("s3_b0_re", m_re3, 16'h0030);
        chk("s3_b0_im", m_im3, 16'hFFCF);
        m_ready = 1'b1;
        n = 0;
        while (m_idx3 != 3'd2 && n < 20) begin tick(); n++; end
        m_ready = 1'b0;
        chk("s3_b2_re", m_re3, 16'h0034);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_m_valid", m_valid3, 0);
        chk("rst_mid_m_re",    m_re3,    0);
        chk("rst_mid_m_im",    m_im3,    0);
        chk("rst_mid_m_idx",   m_idx3,   0);
        chk("rst_mid_m_last",  m_last3,  0);
        chk("rst_mid_fcnt",    fcnt3,    0);
        chk("rst_mid_s_ready", s_ready3, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_m_valid", m_valid3, 0);
        chk("post_rst_busy",    busy3,    0);
        chk("post_rst_fcnt",    fcnt3,    0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
Frame sequencer wrapped around the team's combinational 8-point 16-bit FFT datapath. It collects 8 serially streamed samples into an input buffer and holds them stable on the datapath inputs. After a settle interval it captures the 8 real and 8 imaginary result words, then streams the bins out one per handshake. It fills the next frame while the current one drains.

Parameters:
W, 16, sample/bin word width
SETTLE, 1, extra cycles the datapath inputs are held stable before capture (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous clear of all frame state, highest priority after rst_n
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts a sample this cycle
s_data  in  W  input sample, time order x0..x7
fft_x  out  8*W  datapath inputs; x_k on bits [W*k+W-1:W*k]
fft_re  in  8*W  datapath real results; bin k on bits [W*k+W-1:W*k]
fft_im  in  8*W  datapath imaginary results, same packing
m_valid  out  1  output bin valid
m_ready  in  1  downstream accepts bin
m_re  out  W  real part of current bin
m_im  out  W  imaginary part of current bin
m_idx  out  3  bin index 0..7
m_last  out  1  high with bin 7
busy  out  1  a frame is in flight
frame_cnt  out  16  frames captured, wraps FFFF->0000

Behaviour:
- Input FSM states: IDLE, FILL, HOLD, COMPUTE. Async reset puts the FSM in IDLE. IDLE->FILL unconditionally on the next clock.
- s_ready is registered. It is 1 only in FILL, so it is 0 during reset and on the first cycle after reset.
- FILL: on s_valid&&s_ready, in_buf[wr_idx]<=s_data and wr_idx++. On the accept with wr_idx==7, wr_idx<=0 and s_ready<=0.
  - Next state is COMPUTE if the output buffer is empty or is releasing this cycle (m_valid&&m_ready&&m_last).
  - Otherwise the next state is HOLD.
- HOLD: go to COMPUTE on the cycle the output buffer is empty, or the cycle it releases (same-cycle rule as in FILL).
- COMPUTE: cnt starts at 0 and increments each cycle. On the cycle cnt==SETTLE:
  - out_re[k]/out_im[k] <= fft_re/fft_im slices;
  - out_full<=1, frame_cnt++;
  - next state FILL with s_ready<=1.
- fft_x is driven directly from in_buf. It is stable from the cycle after the final sample accept through capture.
- Latency: last sample accepted in cycle T; capture at end of cycle T+1+SETTLE; m_valid first high in cycle T+2+SETTLE (no HOLD stall).
- Output side:
  - m_valid=out_full.
  - m_re/m_im=out buffer entry [rd_idx]; m_idx=rd_idx.
  - m_last=m_valid&&(rd_idx==7).
  - On m_valid&&m_ready: rd_idx++. On the bin-7 handshake, out_full<=0 and rd_idx<=0.
  - m_re/m_im/m_idx must stay stable while m_valid&&!m_ready.
- Capture never overwrites an undrained output buffer. Output order is always bins 0..7.
- The controller performs no arithmetic; results pass through bit-exact.
- busy = (state!=FILL && state!=IDLE) || out_full || wr_idx!=0.
- abort: same effect as reset except the state goes to FILL directly. Clears wr_idx, rd_idx, cnt, out_full, in_buf, out buffer. frame_cnt is held.
- Reset mid-operation: all registers cleared immediately, asynchronously. No partial bin is emitted after deassertion.
- Reset values: s_ready 0, m_valid 0, m_re 0, m_im 0, m_idx 0, m_last 0, fft_x 0, busy 0, frame_cnt 0.

Decomposition:
- Shared package fft8_pkg holds:
  - constants N=8, IDX_W=3, W;
  - input FSM state enum (IDLE, FILL, HOLD, COMPUTE);
  - helper function for W-bit slice extraction.
- One sub-module, fft8_out_buf: 8-entry re/im capture register, rd_idx counter, m_* handshake logic, release indication to the FSM.

Test Plan:
Bench stub datapath for all tests: fft_re_k=x_k+k, fft_im_k=~x_k.
- Reset release: rst_n low 3 cycles, then high. s_ready=0 first cycle, 1 second cycle. busy=0, m_valid=0.
- Basic frame, SETTLE=1: stream x=0x0010..0x0017 back-to-back, m_ready=1.
  - m_valid rises 3 cycles after the last accept.
  - Bins 0..7 are re=0x0010,0x0012,...,0x001E and im=0xFFEF..0xFFE8.
  - m_last only on idx 7; frame_cnt=1.
- Backpressure: hold m_ready=0 for 10 cycles mid-drain at idx 3. m_re=0x0016 held stable; drain resumes at idx 4 without loss.
- Overlap/HOLD: second frame fully streamed while the first is stalled at idx 5. FSM sits in HOLD with s_ready=0. COMPUTE entered the same cycle as the bin-7 handshake. Second frame's bins follow with correct values.
- abort after 5 samples accepted: wr_idx=0, busy=0. A fresh 8-sample frame yields results from the new samples only. frame_cnt unchanged.
- SETTLE=3 plus async reset mid-drain at idx 2:
  - capture occurs 4 cycles after the last accept;
  - reset drops m_valid within the same cycle;
  - post-reset m_* outputs and frame_cnt are all 0.
